// File: rtl/sec_timebase.sv
// sec_timebase: 1 Hz time-of-day source with prescaler, h/m/s fields and load port.
// Ports: clk, rst (sync, active-high), run, set_en/set_hour/set_min/set_sec in;
//        sec_clk, sec_tick, cur_sec, hour, min, sec, day_wrap, set_err out (all registered).
module sec_timebase #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        set_en,
  input  logic [4:0]  set_hour,
  input  logic [5:0]  set_min,
  input  logic [5:0]  set_sec,
  output logic        sec_clk,
  output logic        sec_tick,
  output logic [16:0] cur_sec,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        day_wrap,
  output logic        set_err
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nx;

  logic          set_ok;
  logic          load;
  logic          pre_wrap;
  logic          advance;
  logic          last_of_day;
  logic [16:0]   set_sum;

  logic [5:0]    sec_nx;
  logic [5:0]    min_nx;
  logic [4:0]    hour_nx;
  logic [16:0]   cur_nx;

  // Load validation and seconds-of-day sum at full 17-bit width.
  always_comb begin
    set_ok  = (set_hour <= 5'd23)
            && (set_min <= 6'd59)
            && (set_sec <= 6'd59);
    set_sum = ({12'd0, set_hour} * 17'd3600)
            + ({11'd0, set_min} * 17'd60)
            + {11'd0, set_sec};
  end

  // A valid load overrides a coincident prescaler wrap;
  // a rejected load does not.
  always_comb begin
    load     = set_en && set_ok;
    pre_wrap = run && (pre == PRE_MAX);
    advance  = pre_wrap && !load;
  end

  always_comb begin
    pre_nx = pre;
    if (load)
      pre_nx = '0;
    else if (run)
      pre_nx = pre_wrap ? '0 : pre + PW'(1);
  end

  // Carry chain for a one-second advance.
  always_comb begin
    sec_nx      = sec;
    min_nx      = min;
    hour_nx     = hour;
    last_of_day = 1'b0;
    if (sec != 6'd59) begin
      sec_nx = sec + 6'd1;
    end else begin
      sec_nx = 6'd0;
      if (min != 6'd59) begin
        min_nx = min + 6'd1;
      end else begin
        min_nx = 6'd0;
        if (hour != 5'd23) begin
          hour_nx = hour + 5'd1;
        end else begin
          hour_nx     = 5'd0;
          last_of_day = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (cur_sec == 17'd86399)
      cur_nx = 17'd0;
    else
      cur_nx = cur_sec + 17'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      sec_clk  <= 1'b0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      set_err  <= 1'b0;
      cur_sec  <= '0;
      hour     <= '0;
      min      <= '0;
      sec      <= '0;
    end else begin
      pre      <= pre_nx;
      // Registered from the next prescaler value so it
      // tracks pre >= CLK_HZ/2 in the same cycle.
      sec_clk  <= (pre_nx >= PRE_HALF);
      sec_tick <= advance;
      day_wrap <= advance && last_of_day;
      set_err  <= set_en && !set_ok;
      if (load) begin
        hour    <= set_hour;
        min     <= set_min;
        sec     <= set_sec;
        cur_sec <= set_sum;
      end else if (advance) begin
        hour    <= hour_nx;
        min     <= min_nx;
        sec     <= sec_nx;
        cur_sec <= cur_nx;
      end
    end
  end

endmodule

// File: tb/tb_sec_timebase.sv
// tb_sec_timebase: directed plus random checks of sec_timebase (CLK_HZ = 10)
// against a seconds-of-day reference model.
module tb_sec_timebase;

  localparam int HZ = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        set_en = 1'b0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_min = '0;
  logic [5:0]  set_sec = '0;
  logic        sec_clk;
  logic        sec_tick;
  logic [16:0] cur_sec;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        day_wrap;
  logic        set_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time of day as one integer, prescaler as a count.
  int m_tod  = 0;
  int m_pre  = 0;
  int m_tick = 0;
  int m_wrap = 0;
  int m_err  = 0;

  sec_timebase #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst(rst), .run(run), .set_en(set_en),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .sec_clk(sec_clk), .sec_tick(sec_tick), .cur_sec(cur_sec),
    .hour(hour), .min(min), .sec(sec),
    .day_wrap(day_wrap), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit ok;
    if (rst) begin
      m_tod = 0; m_pre = 0;
      m_tick = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_tick = 0; m_wrap = 0; m_err = 0;
      ok = (int'(set_hour) < 24) && (int'(set_min) < 60)
           && (int'(set_sec) < 60);
      if (set_en && !ok) m_err = 1;
      if (set_en && ok) begin
        m_tod = set_hour * 3600 + set_min * 60 + set_sec;
        m_pre = 0;
      end else if (run) begin
        if (m_pre == HZ - 1) begin
          m_pre  = 0;
          m_tod  = (m_tod + 1) % 86400;
          m_tick = 1;
          m_wrap = (m_tod == 0);
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  task automatic check_all();
    check("cur_sec",  32'(cur_sec),  m_tod);
    check("hour",     32'(hour),     m_tod / 3600);
    check("min",      32'(min),      (m_tod / 60) % 60);
    check("sec",      32'(sec),      m_tod % 60);
    check("sec_clk",  32'(sec_clk),  (m_pre >= HZ / 2) ? 1 : 0);
    check("sec_tick", 32'(sec_tick), m_tick);
    check("day_wrap", 32'(day_wrap), m_wrap);
    check("set_err",  32'(set_err),  m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic load(input int h, input int m, input int s);
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    set_en = 1'b1;
    step();
    set_en = 1'b0;
  endtask

  task automatic run_to_pre(input int p);
    for (int i = 0; i < 2 * HZ && m_pre != p; i++) step();
    check("reach_pre", 32'(m_pre), p);
  endtask

  initial begin
    int ticks_seen;
    int gap;

    // Reset and first second.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    run = 1'b1;
    for (int i = 1; i <= HZ; i++) begin
      step();
      check("first_tick", 32'(sec_tick), (i == HZ) ? 1 : 0);
      check("first_clk", 32'(sec_clk), (i >= HZ / 2 && i < HZ) ? 1 : 0);
    end
    check("first_cur", 32'(cur_sec), 1);
    check("first_sec", 32'(sec), 1);

    // Carry chain.
    load(0, 0, 59);
    for (int i = 0; i < HZ; i++) step();
    check("carry_min", 32'(cur_sec), 60);
    load(0, 59, 59);
    for (int i = 0; i < HZ; i++) step();
    check("carry_hr", 32'(cur_sec), 3600);
    check("carry_hr_h", 32'(hour), 1);

    // Day wrap.
    load(23, 59, 59);
    check("pre_wrap_cur", 32'(cur_sec), 86399);
    for (int i = 0; i < HZ; i++) step();
    check("wrap_cur", 32'(cur_sec), 0);
    check("wrap_pulse", 32'(day_wrap), 1);
    step();
    check("wrap_once", 32'(day_wrap), 0);

    // Rejected loads (time frozen so it must stay put).
    run = 1'b0;
    load(12, 34, 56);
    load(24, 0, 0);
    check("rej_h_err", 32'(set_err), 1);
    load(12, 60, 0);
    check("rej_m_err", 32'(set_err), 1);
    load(12, 0, 60);
    check("rej_s_err", 32'(set_err), 1);
    check("rej_cur", 32'(cur_sec), 12 * 3600 + 34 * 60 + 56);
    step();
    check("rej_clear", 32'(set_err), 0);
    run = 1'b1;

    // Load colliding with the prescaler wrap.
    run_to_pre(HZ - 1);
    load(5, 6, 7);
    check("coll_cur", 32'(cur_sec), 18367);
    check("coll_tick", 32'(sec_tick), 0);
    gap = 0;
    for (int i = 0; i < 3 * HZ && !sec_tick; i++) begin
      step();
      gap++;
    end
    check("coll_gap", 32'(gap), HZ);

    // Freeze mid-second, then resume.
    run_to_pre(3);
    run = 1'b0;
    for (int i = 0; i < 23; i++) step();
    check("frz_cur", 32'(cur_sec), 18368);
    run = 1'b1;
    gap = 0;
    for (int i = 0; i < 3 * HZ && !sec_tick; i++) begin
      step();
      gap++;
    end
    check("frz_gap", 32'(gap), HZ - 3);

    // Reset in mid-count.
    run_to_pre(7);
    rst = 1'b1;
    step();
    check("rst_cur", 32'(cur_sec), 0);
    check("rst_clk", 32'(sec_clk), 0);
    rst = 1'b0;

    // Random phase.
    ticks_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      run    = ($urandom_range(0, 9) != 0);
      set_en = ($urandom_range(0, 29) == 0);
      set_hour = 5'($urandom_range(0, 25));
      set_min  = 6'($urandom_range(0, 62));
      set_sec  = 6'($urandom_range(0, 62));
      if ($urandom_range(0, 3) == 0) begin
        set_hour = 5'd23; set_min = 6'd59;
      end
      step();
      if (sec_tick) ticks_seen++;
    end
    rst = 1'b0; set_en = 1'b0; run = 1'b1;
    check("rand_ticks_nonzero", 32'(ticks_seen > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sec_timebase.md
# sec_timebase

Time-of-day source for the digital clock. It divides the system clock into the 1 Hz `sec_clk` and maintains the seconds-of-day count `cur_sec`, which the alarm comparators sample on `posedge sec_clk`. It also provides matching hour/minute/second fields for the display path and a load port for the time-set UI. It is the producing end of the `sec_clk`/`cur_sec` interface.

## Interface
- `CLK_HZ`, default 100_000_000: system clock cycles per second; must be even and ≥ 4.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: 1 = time advances; 0 = prescaler and time frozen.
- `set_en` input 1: one-cycle load strobe.
- `set_hour` input 5: load value, 0..23.
- `set_min` input 6: load value, 0..59.
- `set_sec` input 6: load value, 0..59.
- `sec_clk` output 1: 1 Hz square wave, registered.
- `sec_tick` output 1: one-`clk` pulse on each time advance.
- `cur_sec` output 17: seconds of day, 0..86399, registered.
- `hour` output 5: hour field, registered.
- `min` output 6: minute field, registered.
- `sec` output 6: second field, registered.
- `day_wrap` output 1: one-`clk` pulse when 23:59:59 wraps to 00:00:00.
- `set_err` output 1: one-`clk` pulse when a load is rejected.

## Operation
- **Prescaler.** `pre` counts 0..CLK_HZ-1. Width is clog2(CLK_HZ).
- **sec_clk.** `sec_clk` = 1 exactly while `pre` ≥ CLK_HZ/2, as a registered output.
  - `cur_sec` therefore changes while `sec_clk` = 0.
  - `cur_sec` is stable for CLK_HZ/2 cycles before every `sec_clk` rising edge.
- **Advance.** When `run` = 1, `pre` increments each cycle.
  - On `pre` = CLK_HZ-1, `pre` wraps to 0 and time advances by one second.
- **Time update rules.** Fields and `cur_sec` update together in one cycle:
  - `sec` 59 → 0 carries into `min`.
  - `min` 59 → 0 carries into `hour`.
  - `hour` 23 → 0 asserts `day_wrap`.
  - `cur_sec` increments; 86399 → 0.
  - Invariant, every cycle: `cur_sec` = `hour`·3600 + `min`·60 + `sec`.
- **Load.** `set_en` with all fields in range loads `hour`/`min`/`sec`.
  - `cur_sec` is loaded with the 17-bit sum `set_hour`·3600 + `set_min`·60 + `set_sec`, computed at ≥ 17-bit width.
  - `pre` clears to 0, so the next advance comes a full second later.
  - A load does not pulse `sec_tick` or `day_wrap`.
- **Rejected load.** If any field is out of range, all state is unchanged and `set_err` pulses.
- **Priority.** `rst` > `set_en` > advance.
  - `set_en` in the same cycle as the wrap of `pre` means the load wins and no advance happens.
  - A rejected load in that same cycle still permits the advance.
- **run = 0.** `pre`, the time fields, and `sec_clk` hold.
  - `set_en` still operates while `run` = 0.
- **Reset values.** All of `pre`, `cur_sec`, `hour`, `min`, `sec`, `sec_clk`, `sec_tick`, `day_wrap`, `set_err` reset to 0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- **Advance.** Cycle N has `pre` = CLK_HZ-1 and `run` = 1. In cycle N+1:
  - `cur_sec` and the fields hold their new values.
  - `sec_tick` = 1 for that cycle only.
  - `pre` = 0 and `sec_clk` = 0.
  - `day_wrap` = 1 in the same cycle if it was a wrap.
- **sec_clk edge.** `sec_clk` rises in the cycle after `pre` reaches CLK_HZ/2-1, i.e. CLK_HZ/2 cycles after `sec_tick`.
- **Load.** `set_en` in cycle N gives the new values, or `set_err`, in cycle N+1.
- **Reset mid-operation.** `rst` in cycle N means all outputs read 0 in N+1, including a pulse that was due in that cycle. Counting resumes from `pre` = 0.
- **Rate.** With `run` held at 1, there is exactly one `sec_tick` per CLK_HZ cycles.

## Test plan
All scenarios use CLK_HZ = 10.
- **Reset and first second.** Release reset, hold `run` = 1.
  - `sec_tick` appears on cycle 10 after release; `cur_sec` = 1, `sec` = 1.
  - `sec_clk` reads 0 for 5 cycles, then 1 for 5 cycles.
  - The invariant is checked every cycle.
- **Carry chain.** Load 00:00:59, then run.
  - The next tick gives 00:01:00 and `cur_sec` = 60.
  - Load 00:59:59 → 01:00:00 and `cur_sec` = 3600.
- **Day wrap.** Load 23:59:59; `cur_sec` reads 86399.
  - The next tick gives 00:00:00, `cur_sec` = 0, `day_wrap` = 1 for exactly one cycle.
- **Rejected loads.** Load 24:00:00, then 12:60:00, then 12:00:60.
  - Each gives one `set_err` pulse with time unchanged.
- **Load collides with advance.** Assert `set_en` (05:06:07) in the same cycle as `pre` = 9.
  - Result is 05:06:07, `cur_sec` = 18367, no `sec_tick`.
  - The next tick comes 10 cycles later.
- **Freeze and mid-count reset.**
  - Drop `run` for 23 cycles: time and `sec_clk` are frozen, and the tick period resumes from the same `pre`.
  - Assert `rst` at `pre` = 7: all outputs are 0 the next cycle.
